// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel-enable divider plus horizontal/vertical phase FSMs.
// Optional completed-frame counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_ctrl #(
  parameter int   DIV      = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,output logic [15:0] frame_cnt
`endif
);

  localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [10:0]     H_B1     = 11'(H_ACTIVE);
  localparam logic [10:0]     H_B2     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]     H_B3     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]     H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0]     V_B1     = 11'(V_ACTIVE);
  localparam logic [10:0]     V_B2     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]     V_B3     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0]     V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} phase_t;

  // Phase from cumulative boundaries; a zero-length phase is never returned.
  function automatic phase_t phase_of(input logic [10:0] cnt, input logic [10:0] b1,
                                      input logic [10:0] b2, input logic [10:0] b3);
    if (cnt < b1)      return ST_ACTIVE;
    else if (cnt < b2) return ST_FRONT;
    else if (cnt < b3) return ST_SYNC;
    else               return ST_BACK;
  endfunction

  logic [DW-1:0] r_div;
  logic [10:0]   r_h_cnt;
  logic [10:0]   r_v_cnt;
  phase_t        r_h_st;
  phase_t        r_v_st;
  logic          w_h_wrap;
  logic [10:0]   w_h_nxt;
  logic [10:0]   w_v_nxt;
  logic          w_de_now;
`ifdef VGA_FRAME_CNT_EN
  logic          r_started;
`endif

  assign pix_en = reset & en & (r_div == DIV_LAST);

  // Next raster position: V advances only on the H wrap.
  always_comb begin
    w_h_wrap = (r_h_cnt == H_LAST);
    w_h_nxt  = w_h_wrap ? 11'd0 : r_h_cnt + 11'd1;
    w_de_now = (r_h_st == ST_ACTIVE) && (r_v_st == ST_ACTIVE);
    if (!w_h_wrap)              w_v_nxt = r_v_cnt;
    else if (r_v_cnt == V_LAST) w_v_nxt = 11'd0;
    else                        w_v_nxt = r_v_cnt + 11'd1;
  end

  // Pixel clock-enable divider.
  always_ff @(posedge clock) begin
    if (!reset)                r_div <= '0;
    else if (!en)              r_div <= r_div;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                       r_div <= r_div + DW'(1);
  end

  // Timing FSMs and registered outputs, reflecting the position before it advances.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_h_cnt     <= 11'd0;
      r_v_cnt     <= 11'd0;
      r_h_st      <= ST_ACTIVE;
      r_v_st      <= ST_ACTIVE;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      de          <= 1'b0;
      x           <= 11'd0;
      y           <= 11'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      frame_cnt   <= 16'd0;
      r_started   <= 1'b0;
`endif
    end else if (pix_en) begin
      r_h_cnt     <= w_h_nxt;
      r_v_cnt     <= w_v_nxt;
      r_h_st      <= phase_of(w_h_nxt, H_B1, H_B2, H_B3);
      r_v_st      <= phase_of(w_v_nxt, V_B1, V_B2, V_B3);
      hsync       <= (r_h_st == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (r_v_st == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      de          <= w_de_now;
      if (w_de_now) begin
        x <= r_h_cnt;
        y <= r_v_cnt;
      end else begin
        x <= x;
        y <= y;
      end
      line_start  <= (r_h_cnt == 11'd0);
      frame_start <= (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
`ifdef VGA_FRAME_CNT_EN
      // The very first frame origin after reset starts frame 0 rather than completing one.
      if ((r_h_cnt == 11'd0) && (r_v_cnt == 11'd0)) begin
        r_started <= 1'b1;
        frame_cnt <= r_started ? frame_cnt + 16'd1 : frame_cnt;
      end else begin
        r_started <= r_started;
        frame_cnt <= frame_cnt;
      end
`endif
    end else begin
      r_h_cnt <= r_h_cnt;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl: two small-raster instances (divided and
// undivided with zero porches) compared every cycle against an arithmetic raster model.
module tb_vga_timing_ctrl;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] x;
    logic [10:0] y;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } outs_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en    = 1'b0;
  always #5 clock = ~clock;

  logic        pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [10:0] x_a, y_a;
  logic [15:0] fc_a;
  logic        pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [10:0] x_b, y_b;
  logic [15:0] fc_b;

  int n_checks = 0;
  int n_errors = 0;
  int m_a = 0;
  int m_b = 0;
  bit chk_on = 1'b0;

  vga_timing_ctrl #(.DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
                    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)) u_a (
    .clock(clock), .reset(reset), .en(en), .pix_en(pe_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_ctrl #(.DIV(1), .H_ACTIVE(5), .H_FP(0), .H_SYNC(2), .H_BP(0),
                    .V_ACTIVE(3), .V_FP(0), .V_SYNC(1), .V_BP(0), .SYNC_POL(1'b1)) u_b (
    .clock(clock), .reset(reset), .en(en), .pix_en(pe_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_a = 16'd0;
  assign fc_b = 16'd0;
`endif

  // Outputs after m enabled clocks since reset: strobe s = m/dv - 1 sits at raster position s.
  function automatic outs_t model(input int m, input int dv, input int ha, input int hfp,
                                  input int hsw, input int hbp, input int va, input int vfp,
                                  input int vsw, input int vbp, input bit pol);
    outs_t o;
    int ht, vt, s, p, h, v;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    o.hs = ~pol; o.vs = ~pol; o.de = 1'b0; o.x = 11'd0; o.y = 11'd0;
    o.ls = 1'b0; o.fs = 1'b0; o.fc = 16'd0;
    if (m >= dv) begin
      s = m / dv - 1;
      p = s % (ht * vt);
      h = p % ht;
      v = p / ht;
      o.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
      o.vs = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
      o.de = (h < ha) && (v < va);
      if (v >= va)      begin o.x = 11'(ha - 1); o.y = 11'(va - 1); end
      else if (h >= ha) begin o.x = 11'(ha - 1); o.y = 11'(v);      end
      else              begin o.x = 11'(h);      o.y = 11'(v);      end
      o.ls = (h == 0);
      o.fs = (p == 0);
      o.fc = 16'(s / (ht * vt));
    end
`ifndef VGA_FRAME_CNT_EN
    o.fc = 16'd0;
`endif
    return o;
  endfunction

  task automatic cmp_inst(input string nm, input outs_t act, input outs_t exp,
                          input logic pa, input logic px);
    n_checks++;
    if ({pa, act} !== {px, exp}) begin
      n_errors++;
      $display("FAIL %s t=%0t pix_en act=%b exp=%b outs act=%h exp=%h", nm, $time, pa, px, act, exp);
    end
  endtask

  task automatic pin(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  // Model time base: count of enabled, non-reset clock edges per instance.
  always @(posedge clock) begin
    if (!reset) begin
      m_a    <= 0;
      m_b    <= 0;
      chk_on <= 1'b1;
    end else if (en) begin
      m_a <= m_a + 1;
      m_b <= m_b + 1;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (chk_on) begin
      cmp_inst("inst_a", {hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a, fc_a},
               model(m_a, 3, 16, 2, 3, 4, 6, 1, 2, 1, 1'b0), pe_a,
               reset && en && (m_a % 3 == 2));
      cmp_inst("inst_b", {hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b, fc_b},
               model(m_b, 1, 5, 0, 2, 0, 3, 0, 1, 0, 1'b1), pe_b,
               reset && en);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0;
    step(3);
    pin("reset_de_a", de_a, 0);
    pin("reset_hs_a", hs_a, 1);
    pin("reset_hs_b", hs_b, 0);
    reset = 1'b1; en = 1'b1;
    step(2);
    pin("pix_en_a_edge2", pe_a, 1);
    pin("pix_en_b_edge2", pe_b, 1);
    step(1);
    pin("first_strobe_de", de_a, 1);
    pin("first_strobe_x", x_a, 0);
    pin("first_strobe_fs", fs_a, 1);
    pin("first_strobe_ls", ls_a, 1);
    pin("b_edge3_x", x_b, 2);
    step(54);
    pin("a_hsync_start", hs_a, 0);
    pin("a_hblank_x_hold", x_a, 15);
    pin("a_hblank_de", de_a, 0);
    pin("b_line2_fs", fs_b, 1);
    step(396);
    pin("a_vblank_y_hold", y_a, 5);
    pin("a_vblank_de", de_a, 0);
    pin("a_vfront_vsync", vs_a, 1);
    step(75);
    pin("a_vsync_on", vs_a, 0);
    step(225);
    pin("a_frame2_fs", fs_a, 1);
    pin("a_frame2_x", x_a, 0);
    pin("b_vsync_pos", vs_b, 1);
    pin("b_vblank_x", x_b, 4);
`ifdef VGA_FRAME_CNT_EN
    pin("a_frame_cnt_1", fc_a, 1);
    pin("b_frame_cnt_26", fc_b, 26);
`endif
    en = 1'b0;
    step(50);
    pin("freeze_fs", fs_a, 1);
    pin("freeze_x", x_a, 0);
    pin("freeze_pix_en", pe_a, 0);
    en = 1'b1;
    step(3);
    pin("resume_x", x_a, 1);
    pin("resume_fs", fs_a, 0);
    pin("resume_b_hsync", hs_b, 1);
    for (int i = 0; i < 20000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 2999) != 0);
      step(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
